// File: rtl/hex_token_assembler_pkg.sv
// Shared types and character constants for the hex token assembler.
// Imported by the classifier, the interface users and the top.
package hex_token_assembler_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    HEX     = 2'd0,
    DELIM   = 2'd1,
    ILLEGAL = 2'd2
  } char_class_e;

endpackage

// File: rtl/hex_token_assembler_if.sv
// Byte-in / word-out handshake bundle of the hex token assembler.
// master drives bytes and word_ready; slave is the assembler.
interface hex_token_assembler_if #(
  parameter int DIGITS = 4
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic [4*DIGITS-1:0] word_data;
  logic [CNT_W-1:0]    word_ndigits;
  logic                word_valid;
  logic                word_ready;
  logic                err_pulse;
  logic                busy;

  modport master (
    output rx_data, rx_valid, word_ready,
    input  rx_ready, word_data, word_ndigits,
    input  word_valid, err_pulse, busy
  );

  modport slave (
    input  rx_data, rx_valid, word_ready,
    output rx_ready, word_data, word_ndigits,
    output word_valid, err_pulse, busy
  );
endinterface

// File: rtl/hex_token_assembler_classify.sv
// ASCII byte classifier: hex digit, delimiter or illegal.
// Purely combinational; nibble is 0 for non-hex bytes.
module ascii_char_classify
  import hex_token_assembler_pkg::*;
(
  input  logic [7:0]  ch,
  output logic [3:0]  nibble,
  output char_class_e cls
);

  always_comb begin
    nibble = 4'h0;
    cls    = ILLEGAL;
    unique case (1'b1)
      (ch >= 8'h30 && ch <= 8'h39): begin
        nibble = ch[3:0];
        cls    = HEX;
      end
      // 'A'-'F' and 'a'-'f' share low nibbles 1..6
      (ch >= 8'h41 && ch <= 8'h46),
      (ch >= 8'h61 && ch <= 8'h66): begin
        nibble = ch[3:0] + 4'd9;
        cls    = HEX;
      end
      (ch == CHAR_CR || ch == CHAR_LF || ch == CHAR_SP): begin
        cls = DELIM;
      end
      default: begin
        cls = ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/hex_token_assembler.sv
// Packs ASCII hex digits MSB-first into words of DIGITS nibbles.
// Emits on delimiter or full word; illegal bytes discard the token.
module hex_token_assembler
  import hex_token_assembler_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst_n,
  hex_token_assembler_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);

  state_e           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [3:0]  nib;
  char_class_e cls;
  logic        accept;

  ascii_char_classify u_cls (
    .ch     (bus.rx_data),
    .nibble (nib),
    .cls    (cls)
  );

  assign bus.rx_ready     = (state_q != HOLD);
  assign bus.word_valid   = (state_q == HOLD);
  assign bus.word_data    = acc_q;
  assign bus.word_ndigits = cnt_q;
  assign bus.err_pulse    = err_q;
  assign bus.busy         = (state_q != IDLE);

  assign accept = bus.rx_valid && bus.rx_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (cls)
            HEX: begin
              acc_d   = W'(nib);
              cnt_d   = CNT_W'(1);
              state_d = (DIGITS == 1) ? HOLD : ACCUM;
            end
            DELIM: ;
            default: begin
              err_d   = 1'b1;
              state_d = DISCARD;
            end
          endcase
        end
      end
      ACCUM: begin
        if (accept) begin
          case (cls)
            HEX: begin
              acc_d = (acc_q << 4) | W'(nib);
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_d == FULL) state_d = HOLD;
            end
            DELIM: state_d = HOLD;
            default: begin
              err_d   = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = DISCARD;
            end
          endcase
        end
      end
      HOLD: begin
        if (bus.word_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (accept && cls == DELIM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_hex_token_assembler.sv
// Table-driven bench with a word scoreboard for hex_token_assembler.
// Hand sequences cover latency, err width, backpressure and reset.
module tb_hex_token_assembler;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  n;
  } word_t;

  typedef struct {
    string       s;
    int          nw;
    logic [15:0] d0;
    logic [2:0]  n0;
    logic [15:0] d1;
    logic [2:0]  n1;
    int          nerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_token_assembler_if #(.DIGITS(4)) bus ();

  hex_token_assembler #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    total  = 0;
  int    passed = 0;
  int    err_cnt = 0;
  word_t exp_q[$];
  word_t mon_e;
  vec_t  vecs[7];

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic vec_t mk(string s, int nw, logic [15:0] d0,
                              logic [2:0] n0, logic [15:0] d1,
                              logic [2:0] n1, int nerr);
    vec_t v;
    v.s = s; v.nw = nw; v.d0 = d0; v.n0 = n0;
    v.d1 = d1; v.n1 = n1; v.nerr = nerr;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.err_pulse) err_cnt++;
    if (rst_n && bus.word_valid && bus.word_ready) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("word_data", 32'(bus.word_data), 32'(mon_e.d));
        chk("word_ndigits", 32'(bus.word_ndigits), 32'(mon_e.n));
      end else begin
        chk("unexpected_word", 32'(bus.word_valid), 32'd0);
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic [2:0] n);
    word_t w;
    w.d = d;
    w.n = n;
    exp_q.push_back(w);
  endtask

  // Returns #1 after the posedge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.rx_ready) begin
      chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int c = 0; c < s.len(); c++) send_byte(s[c]);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    bus.rx_valid = 1'b0;
    while (exp_q.size() > 0 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_word_valid"}, 32'(bus.word_valid), 32'd0);
    chk({tag, "_word_data"}, 32'(bus.word_data), 32'd0);
    chk({tag, "_ndigits"}, 32'(bus.word_ndigits), 32'd0);
    chk({tag, "_err"}, 32'(bus.err_pulse), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
  endtask

  initial begin
    int e0;
    vecs[0] = mk("1A3\015", 1, 16'h01A3, 3'd3, 16'h0, 3'd0, 0);
    vecs[1] = mk("beef cafe\n", 2, 16'hBEEF, 3'd4, 16'hCAFE, 3'd4, 0);
    vecs[2] = mk("12345\015", 2, 16'h1234, 3'd4, 16'h0005, 3'd1, 0);
    vecs[3] = mk("1G2\0157\015", 1, 16'h0007, 3'd1, 16'h0, 3'd0, 1);
    vecs[4] = mk("  \015\n", 0, 16'h0, 3'd0, 16'h0, 3'd0, 0);
    vecs[5] = mk("x9z \n", 0, 16'h0, 3'd0, 16'h0, 3'd0, 1);
    vecs[6] = mk("a\015dEaD\n", 2, 16'h000A, 3'd1, 16'hDEAD, 3'd4, 0);

    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.word_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("after_reset");

    foreach (vecs[i]) begin
      e0 = err_cnt;
      if (vecs[i].nw > 0) push(vecs[i].d0, vecs[i].n0);
      if (vecs[i].nw > 1) push(vecs[i].d1, vecs[i].n1);
      send_str(vecs[i].s);
      drain($sformatf("vec%0d_drained", i));
      chk($sformatf("vec%0d_errs", i), 32'(err_cnt - e0),
          32'(vecs[i].nerr));
    end

    // Word must appear exactly one edge after the delimiter.
    send_byte("5");
    chk("lat_before", 32'(bus.word_valid), 32'd0);
    push(16'h0005, 3'd1);
    send_byte(8'h0D);
    chk("lat_word_valid", 32'(bus.word_valid), 32'd1);
    drain("lat_drained");

    e0 = err_cnt;
    send_byte("G");
    chk("err_high", 32'(bus.err_pulse), 32'd1);
    chk("err_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(bus.err_pulse), 32'd0);
    send_byte("Q");
    chk("discard_no_err", 32'(bus.err_pulse), 32'd0);
    send_byte(8'h20);
    chk("discard_exit", 32'(bus.busy), 32'd0);
    drain("err_drained");
    chk("err_total", 32'(err_cnt - e0), 32'd1);

    bus.word_ready = 1'b0;
    push(16'h00FF, 3'd2);
    send_str("FF\015");
    bus.rx_data  = "3";
    bus.rx_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.word_valid), 32'd1);
      chk("bp_rx_ready", 32'(bus.rx_ready), 32'd0);
      chk("bp_data", 32'(bus.word_data), 32'h00FF);
    end
    @(posedge clk);
    #1;
    bus.word_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    chk("bp_release_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.word_valid), 32'd0);
    drain("bp_drained");

    e0 = err_cnt;
    send_str("AB");
    chk("rst_busy_before", 32'(bus.busy), 32'd1);
    bus.rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h0D);
    drain("rst_drained");
    chk_idle_outputs("post_reset");
    chk("rst_no_err", 32'(err_cnt - e0), 32'd0);

    // Pending word must vanish asynchronously on reset.
    bus.word_ready = 1'b0;
    send_str("7\015");
    chk("pend_valid", 32'(bus.word_valid), 32'd1);
    bus.rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("pend_async_drop", 32'(bus.word_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.word_ready = 1'b1;
    drain("pend_drained");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_token_assembler.md
Name: hex_token_assembler

Overview:
- Sits between the UART receive byte stream and the command/register layer.
- Consumes ASCII characters, decodes hex digits and packs them MSB-first into a word of DIGITS nibbles.
- Emits the word through a valid/ready handshake when a delimiter arrives or the word is full.
- Flags malformed tokens and discards the remainder of the token up to the next delimiter.

Parameters:
- DIGITS, 4, maximum hex digits per word; word width is 4*DIGITS. Legal range 1..8.
- CNT_W, $clog2(DIGITS+1), width of the digit-count output. Derived; not overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  ASCII byte from the UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- word_data  out  4*DIGITS  assembled value, right-justified
- word_ndigits  out  CNT_W  number of digits in word_data (1..DIGITS)
- word_valid  out  1  word available
- word_ready  in  1  consumer accepts word when word_valid && word_ready
- err_pulse  out  1  one-cycle flag: illegal character received
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk); asynchronous active-low reset (rst_n).
- Character classes:
  - hex: '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66).
  - delimiter: 0x0D, 0x0A, 0x20.
  - all other values are illegal.
- FSM states are IDLE, ACCUM, HOLD and DISCARD. Reset state is IDLE.
- Reset values: word_data=0, word_ndigits=0, word_valid=0, err_pulse=0, busy=0. Accumulator and count are 0.
- rx_ready is decoded from state: 1 in IDLE, ACCUM and DISCARD; 0 in HOLD.
- IDLE:
  - hex byte -> acc=digit, cnt=1, go to ACCUM. If DIGITS==1, go to HOLD instead.
  - delimiter -> ignored; stay in IDLE. Empty tokens produce no word.
  - illegal byte -> err_pulse, go to DISCARD.
- ACCUM:
  - hex byte -> acc={acc[4*DIGITS-5:0],digit}, cnt+1. If the new cnt==DIGITS, go to HOLD.
  - delimiter -> go to HOLD with the current acc and cnt.
  - illegal byte -> err_pulse, clear acc and cnt, go to DISCARD. No word is emitted.
- HOLD:
  - word_valid=1; word_data=acc; word_ndigits=cnt. All three hold stable until the handshake completes.
  - On word_ready, go to IDLE and clear acc and cnt. rx_ready returns to 1 on the next cycle.
- DISCARD:
  - hex and illegal bytes are dropped. Illegal bytes raise no further err_pulse.
  - delimiter -> go to IDLE.
- Latency: a byte whose acceptance completes a token produces word_valid on the next clock edge. Minimum of 1 cycle from the accepting handshake.
- Full-word boundary: the word is emitted as soon as DIGITS digits are received. Following digits start a new token. With DIGITS=4, "12345\r" gives 0x1234 (4 digits), then 0x0005 (1 digit).
- A delimiter directly after a full-word emission arrives in IDLE and is ignored.
- Short words are zero-extended in the upper nibbles.
- err_pulse is registered and high for exactly one cycle, in the cycle after the illegal byte is accepted.
- Simultaneous rx_valid and word_ready in HOLD: the word handshake completes; the byte is not accepted (rx_ready=0).
- rx_valid is sampled only when rx_ready=1. The block has no input buffering.
- Reset mid-operation: a partial token and any pending word are discarded. word_valid drops asynchronously; no spurious err_pulse.

Decomposition:
- Shared package holds the character constants CHAR_CR=8'h0D, CHAR_LF=8'h0A and CHAR_SP=8'h20.
- Shared package holds the FSM state enum typedef (IDLE, ACCUM, HOLD, DISCARD) and a char-class enum (HEX, DELIM, ILLEGAL).
- One combinational sub-module, ascii_char_classify:
  - input: 8-bit byte.
  - outputs: 4-bit nibble value and 2-bit class, including lowercase.
- The FSM, accumulator and counter live in the top module.

Test Plan (DIGITS=4, rx_valid held continuously, word_ready=1 unless stated):
- Stream "1A3\r" -> one word: word_data=0x01A3, word_ndigits=3. word_valid is asserted 1 cycle after '\r' is accepted.
- Stream "beef cafe\n" -> words 0xBEEF (4 digits) then 0xCAFE (4 digits). The space and LF after full words are dropped silently.
- Stream "12345\r" -> 0x1234 (4 digits), then 0x0005 (1 digit).
- Stream "1G2\r7\r" -> err_pulse for one cycle after 'G'. '2' and the first '\r' are discarded. Only the word 0x0007 (1 digit) is emitted.
- Hold word_ready=0 for 10 cycles after "FF\r" -> word_valid stays 1 and rx_ready stays 0 throughout, with word_data=0x00FF stable. Release word_ready -> next cycle returns to IDLE and rx_ready=1.
- Assert rst_n=0 after "AB" of "ABCD", then release and send "\r" -> no word emitted, no err_pulse, all outputs at reset values.
